// File: rtl/mult_seq_unit_if.sv
// Operand/result bundle for the sequential multiplier.
// The master side issues requests; the slave side is the multiplier itself.
interface mult_seq_unit_if #(
  parameter int P = 32
);
  logic           start;
  logic [P-1:0]   a;
  logic [P-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*P-1:0] prod;

  modport master (output start, a, b, input busy, done, prod);
  modport slave  (input start, a, b, output busy, done, prod);
endinterface

// File: rtl/mult_seq_unit.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// result registered with a single-cycle done pulse.
module mult_seq_unit #(
  parameter int P = 32
) (
  input logic            clk,
  input logic            rst,
  mult_seq_unit_if.slave bus
);
  localparam int CW = $clog2(P);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t         state;
  logic [P-1:0]   mcand;
  logic [2*P-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [P:0]     sum;
  logic           busy;
  logic           done;
  logic [2*P-1:0] prod;

  // Upper half plus the optional multiplicand; the carry is kept as bit P
  always_comb begin
    sum = {1'b0, acc[2*P-1:P]};
    if (acc[0]) begin
      sum = {1'b0, acc[2*P-1:P]} + {1'b0, mcand};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      prod  <= '0;
      acc   <= '0;
      cnt   <= '0;
      mcand <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.a;
            acc   <= {{P{1'b0}}, bus.b};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= {sum, acc[P-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(P - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          prod  <= acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.prod = prod;
endmodule

// File: tb/tb_mult_seq_unit.sv
// Self-checking bench for mult_seq_unit: cycle-level reference model compared
// every cycle, plus directed cases with hand-computed products.
module tb_mult_seq_unit;
  localparam int P = 32;
  localparam int W = 2 * P;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult_seq_unit_if #(.P(P)) bus ();

  mult_seq_unit #(.P(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  // Reference: an accepted request yields a*b exactly P+1 edges later
  logic [W-1:0] m_prod;
  logic [W-1:0] m_result;
  logic         m_done;
  int           m_left;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_left = 0;
      m_prod = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_prod = m_result;
        end
      end else if (bus.start) begin
        m_result = W'(bus.a) * W'(bus.b);
        m_left   = P + 1;
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0b want %0b", name, cyc, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_bit("model_busy", bus.busy, m_left > 0);
      check_bit("model_done", bus.done, m_done);
      check_word("model_prod", bus.prod, m_prod);
    end
  end

  // One request; operands are scrambled after acceptance to prove they were latched
  task automatic run_op(input logic [P-1:0] av, input logic [P-1:0] bv,
                        input logic [W-1:0] exp, input string name);
    int k;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    k = 0;
    while (!bus.done && k < P + 10) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      check_bit({name, "_timeout"}, 1'b0, 1'b1);
    end else begin
      check_int({name, "_latency"}, k, P + 1);
      check_word(name, bus.prod, exp);
      check_word({name, "_model_pin"}, m_prod, exp);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input string name, input logic [W-1:0] exp);
    int k;
    k = 0;
    while (!bus.done && k < 2 * P + 10) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) check_bit({name, "_timeout"}, 1'b0, 1'b1);
    else           check_word(name, bus.prod, exp);
  endtask

  initial begin
    int ndone;
    int prev;
    int k;
    logic [W-1:0] first_prod;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    check_bit("reset_busy", bus.busy, 1'b0);
    check_bit("reset_done", bus.done, 1'b0);
    check_word("reset_prod", bus.prod, '0);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'd3, 32'd5, 64'd15, "small");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "max");
    run_op(32'h0, 32'h12345678, 64'h0, "zero");
    run_op(32'h80000000, 32'd2, 64'h1_00000000, "msb");

    // Held start: only one result inside the window, second op sees the new A
    bus.a     = 32'd7;
    bus.b     = 32'd6;
    bus.start = 1'b1;
    ndone      = 0;
    first_prod = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 10) bus.a = 32'd9;
      if (bus.done) begin
        ndone++;
        first_prod = bus.prod;
      end
    end
    bus.start = 1'b0;
    check_int("held_start_pulses", ndone, 1);
    check_word("held_start_prod", first_prod, 64'd42);
    wait_done("held_start_second", 64'd54);
    @(negedge clk);

    // Abort mid-calculation
    bus.a     = 32'd100;
    bus.b     = 32'd200;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_bit("abort_busy", bus.busy, 1'b0);
    check_bit("abort_done", bus.done, 1'b0);
    check_word("abort_prod", bus.prod, '0);
    ndone = 0;
    for (int i = 0; i < P + 5; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check_int("abort_no_done", ndone, 0);
    run_op(32'd11, 32'd13, 64'd143, "after_abort");

    // Back-to-back random operands; results must arrive every P+2 cycles
    ndone = 0;
    prev  = -1;
    k     = 0;
    bus.start = 1'b1;
    while (ndone < 1000 && k < 1000 * (P + 2) + 200) begin
      case ($urandom_range(0, 9))
        0:       bus.a = '0;
        1:       bus.a = '1;
        default: bus.a = P'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       bus.b = '0;
        1:       bus.b = '1;
        default: bus.b = P'($urandom);
      endcase
      @(negedge clk);
      k++;
      if (bus.done) begin
        ndone++;
        if (prev >= 0) check_int("spacing", cyc - prev, P + 2);
        prev = cyc;
      end
    end
    bus.start = 1'b0;
    check_int("random_count", ndone, 1000);
    repeat (P + 5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
